// File: rtl/sgbus_stream_xroute.sv
// sgbus_stream_xroute: routes sgbus packets from one AXI-Stream ingress to
// EngNum engines by header type, and merges engine return streams round-robin.
// Ports: stream_clk, reset (sync, active high); s_axis_* ingress;
// m_eng_axis_* egress to engines; s_eng_axis_* engine returns;
// m_axis_* merged return; rt_type/rt_en routing table; drop_cnt oversize drops.
// Option: define SGBUS_XROUTE_OVERSIZE_DROP_EN to discard pkt_len > MaxPayload.
// Header beat layout: data[7:0] = pkg_type_id, data[31:8] = pkt_len.
// Packets whose pkt_len does not fit the beat counter are framed modulo its width.
package sgbus_xroute_pkg;
  localparam int DataW = 32;
  localparam int TypeW = 8;
  localparam int LenW  = DataW - TypeW;
  typedef logic [DataW-1:0] sgbus_data_t;
  typedef struct packed {
    sgbus_data_t data;
  } sgbus_beat_t;
  typedef struct packed {
    logic        tvalid;
    sgbus_beat_t t;
  } sgbus_axis_req_t;
  typedef struct packed {
    logic tready;
  } sgbus_axis_resp_t;
endpackage

module sgbus_stream_xroute
  import sgbus_xroute_pkg::*;
#(
  parameter type axis_req_t  = sgbus_axis_req_t,
  parameter type axis_resp_t = sgbus_axis_resp_t,
  parameter type axis_data_t = sgbus_data_t,
  parameter int  EngNum      = 4,
  parameter int  MaxPayload  = 128,
  parameter int  DefaultEng  = EngNum - 1
) (
  input  logic              stream_clk,
  input  logic              reset,
  input  axis_req_t         s_axis_req,
  output axis_resp_t        s_axis_resp,
  output axis_req_t         m_eng_axis_req  [EngNum],
  input  axis_resp_t        m_eng_axis_resp [EngNum],
  input  axis_req_t         s_eng_axis_req  [EngNum],
  output axis_resp_t        s_eng_axis_resp [EngNum],
  output axis_req_t         m_axis_req,
  input  axis_resp_t        m_axis_resp,
  input  logic [TypeW-1:0]  rt_type [EngNum],
  input  logic [EngNum-1:0] rt_en,
  output logic [15:0]       drop_cnt
);
  localparam int IdxW = $clog2(EngNum);
  localparam int CntW = $clog2(MaxPayload) + 1;
  typedef logic [IdxW-1:0] idx_t;
  typedef logic [CntW-1:0] cnt_t;

  // ---------------- ingress ----------------
  typedef enum logic [1:0] {
    IN_IDLE,
    IN_FWD,
    IN_DROP
  } in_state_e;

  in_state_e       in_q, in_d;
  idx_t            in_dst_q, in_dst_d;
  idx_t            match, in_sel;
  cnt_t            in_cnt_q, in_cnt_d;
  axis_data_t      in_hdr;
  logic [LenW-1:0] in_len;
  logic            in_hs;
  logic            oversize;

  assign in_hdr = s_axis_req.t.data;
  assign in_len = in_hdr[DataW-1:TypeW];

  // Descending scan so the lowest matching index wins.
  always_comb begin
    match = idx_t'(DefaultEng);
    for (int i = EngNum - 1; i >= 0; i--) begin
      if (rt_en[i] && rt_type[i] == in_hdr[TypeW-1:0]) begin
        match = idx_t'(i);
      end
    end
  end

`ifdef SGBUS_XROUTE_OVERSIZE_DROP_EN
  assign oversize = in_len > LenW'(MaxPayload);
`else
  assign oversize = 1'b0;
`endif

  // Table lookup only applies to the header; body beats follow the latch.
  assign in_sel = (in_q == IN_IDLE) ? match : in_dst_q;

  always_comb begin
    for (int i = 0; i < EngNum; i++) begin
      m_eng_axis_req[i] = '0;
    end
    s_axis_resp = '0;
    if (!reset) begin
      if (in_q == IN_DROP || (in_q == IN_IDLE && oversize)) begin
        s_axis_resp.tready = 1'b1;
      end else begin
        m_eng_axis_req[in_sel] = s_axis_req;
        s_axis_resp            = m_eng_axis_resp[in_sel];
      end
    end
  end

  assign in_hs = s_axis_req.tvalid && s_axis_resp.tready;

  always_comb begin
    in_d     = in_q;
    in_dst_d = in_dst_q;
    in_cnt_d = in_cnt_q;
    if (in_hs) begin
      unique case (in_q)
        IN_IDLE: begin
          in_dst_d = match;
          in_cnt_d = cnt_t'(in_len);
          if (oversize) begin
            in_d = IN_DROP;
          end else if (in_len != '0) begin
            in_d = IN_FWD;
          end
        end
        default: begin
          in_cnt_d = in_cnt_q - 1'b1;
          if (in_cnt_q == cnt_t'(1)) begin
            in_d = IN_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge stream_clk) begin
    if (reset) begin
      in_q     <= IN_IDLE;
      in_dst_q <= '0;
      in_cnt_q <= '0;
    end else begin
      in_q     <= in_d;
      in_dst_q <= in_dst_d;
      in_cnt_q <= in_cnt_d;
    end
  end

`ifdef SGBUS_XROUTE_OVERSIZE_DROP_EN
  always_ff @(posedge stream_clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (in_hs && in_q == IN_IDLE && oversize) begin
      if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`else
  assign drop_cnt = '0;
`endif

  // ---------------- egress ----------------
  typedef enum logic {
    EG_IDLE,
    EG_LOCK
  } eg_state_e;

  eg_state_e       eg_q, eg_d;
  idx_t            gnt_q, gnt_d;
  idx_t            rr_q, rr_d;
  idx_t            pick, eg_sel;
  cnt_t            eg_cnt_q, eg_cnt_d;
  logic            found, eg_open, eg_hs;
  logic [LenW-1:0] eg_len;

  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    for (int k = 0; k < EngNum; k++) begin
      if (!found && s_eng_axis_req[(int'(rr_q) + k) % EngNum].tvalid) begin
        found = 1'b1;
        pick  = idx_t'((int'(rr_q) + k) % EngNum);
      end
    end
  end

  assign eg_sel  = (eg_q == EG_IDLE) ? pick : gnt_q;
  assign eg_open = !reset && (eg_q == EG_LOCK || found);
  assign eg_len  = s_eng_axis_req[eg_sel].t.data[DataW-1:TypeW];

  always_comb begin
    m_axis_req = '0;
    for (int i = 0; i < EngNum; i++) begin
      s_eng_axis_resp[i] = '0;
    end
    if (eg_open) begin
      m_axis_req              = s_eng_axis_req[eg_sel];
      s_eng_axis_resp[eg_sel] = m_axis_resp;
    end
  end

  assign eg_hs = m_axis_req.tvalid && m_axis_resp.tready;

  always_comb begin
    eg_d     = eg_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    eg_cnt_d = eg_cnt_q;
    if (eg_hs) begin
      unique case (eg_q)
        EG_IDLE: begin
          gnt_d    = pick;
          rr_d     = (int'(pick) == EngNum - 1) ? '0 : pick + 1'b1;
          eg_cnt_d = cnt_t'(eg_len);
          if (eg_len != '0) begin
            eg_d = EG_LOCK;
          end
        end
        EG_LOCK: begin
          eg_cnt_d = eg_cnt_q - 1'b1;
          if (eg_cnt_q == cnt_t'(1)) begin
            eg_d = EG_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge stream_clk) begin
    if (reset) begin
      eg_q     <= EG_IDLE;
      gnt_q    <= '0;
      rr_q     <= '0;
      eg_cnt_q <= '0;
    end else begin
      eg_q     <= eg_d;
      gnt_q    <= gnt_d;
      rr_q     <= rr_d;
      eg_cnt_q <= eg_cnt_d;
    end
  end

endmodule

// File: tb/tb_sgbus_stream_xroute.sv
// tb_sgbus_stream_xroute: directed + random bench for sgbus_stream_xroute.
// Packet-level reference model: routing table lookup, round-robin merge.
module tb_sgbus_stream_xroute;
  import sgbus_xroute_pkg::*;

  localparam int N    = 4;
  localparam int MaxP = 128;
`ifdef SGBUS_XROUTE_OVERSIZE_DROP_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sgbus_axis_req_t  s_req;
  sgbus_axis_resp_t s_resp;
  sgbus_axis_req_t  me_req  [N];
  sgbus_axis_resp_t me_resp [N];
  sgbus_axis_req_t  se_req  [N];
  sgbus_axis_resp_t se_resp [N];
  sgbus_axis_req_t  m_req;
  sgbus_axis_resp_t m_resp;
  logic [TypeW-1:0] rt_type [N];
  logic [N-1:0]     rt_en;
  logic [15:0]      drop_cnt;

  sgbus_stream_xroute #(
    .EngNum    (N),
    .MaxPayload(MaxP)
  ) u_dut (
    .stream_clk     (clk),
    .reset          (reset),
    .s_axis_req     (s_req),
    .s_axis_resp    (s_resp),
    .m_eng_axis_req (me_req),
    .m_eng_axis_resp(me_resp),
    .s_eng_axis_req (se_req),
    .s_eng_axis_resp(se_resp),
    .m_axis_req     (m_req),
    .m_axis_resp    (m_resp),
    .rt_type        (rt_type),
    .rt_en          (rt_en),
    .drop_cnt       (drop_cnt)
  );

  int errs   = 0;
  int checks = 0;

  // reference model state
  sgbus_data_t iq[$];
  sgbus_data_t eq[N][$];
  int irem    = 0;
  int idst    = 0;
  bit idrop   = 0;
  int dropped = 0;
  int rr      = 0;
  int egnt    = -1;
  int erem    = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic sgbus_data_t hdr(input int ty, input int len);
    return {LenW'(len), TypeW'(ty)};
  endfunction

  function automatic int route(input logic [TypeW-1:0] ty);
    for (int i = 0; i < N; i++) begin
      if (rt_en[i] && rt_type[i] == ty) return i;
    end
    return N - 1;
  endfunction

  task automatic add_in(input int ty, input int len);
    iq.push_back(hdr(ty, len));
    for (int i = 0; i < len; i++) iq.push_back($urandom);
  endtask

  task automatic add_eg(input int e, input int ty, input int len);
    eq[e].push_back(hdr(ty, len));
    for (int i = 0; i < len; i++) eq[e].push_back($urandom);
  endtask

  function automatic bit busy();
    bit b;
    b = iq.size() != 0;
    for (int e = 0; e < N; e++) begin
      if (eq[e].size() != 0) b = 1'b1;
    end
    return b;
  endfunction

  // mode 0: all ready, 1: random ready, 2: engine 1 not ready
  task automatic step(input int mode);
    bit          ihs, ehs, er;
    int          g;
    sgbus_data_t h;
    ihs = 1'b0;
    ehs = 1'b0;
    for (int e = 0; e < N; e++) begin
      if (mode == 1) me_resp[e].tready = $urandom_range(0, 3) != 0;
      else me_resp[e].tready = !(mode == 2 && e == 1);
      se_req[e].tvalid = eq[e].size() != 0;
      se_req[e].t.data = '0;
      if (eq[e].size() != 0) se_req[e].t.data = eq[e][0];
    end
    m_resp.tready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    s_req.tvalid = iq.size() != 0;
    s_req.t.data = '0;
    if (iq.size() != 0) s_req.t.data = iq[0];
    #4;
    if (iq.size() != 0) begin
      if (irem == 0) begin
        h     = iq[0];
        idst  = route(h[TypeW-1:0]);
        idrop = DropEn && (h[DataW-1:TypeW] > MaxP);
      end
      for (int e = 0; e < N; e++) begin
        chk("ing_vld", me_req[e].tvalid, !idrop && e == idst);
      end
      if (!idrop) chk("ing_data", me_req[idst].t.data, iq[0]);
      er = idrop ? 1'b1 : me_resp[idst].tready;
      chk("ing_rdy", s_resp.tready, er);
      ihs = er;
    end else begin
      for (int e = 0; e < N; e++) chk("ing_vld_idle", me_req[e].tvalid, 0);
    end
    g = egnt;
    if (egnt < 0) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && eq[(rr + k) % N].size() != 0) g = (rr + k) % N;
      end
    end
    if (g >= 0) begin
      chk("eg_vld", m_req.tvalid, 1);
      chk("eg_data", m_req.t.data, eq[g][0]);
      for (int e = 0; e < N; e++) begin
        chk("eg_rdy", se_resp[e].tready, (e == g) ? m_resp.tready : 1'b0);
      end
      ehs = m_resp.tready;
    end else begin
      chk("eg_vld_idle", m_req.tvalid, 0);
      for (int e = 0; e < N; e++) chk("eg_rdy_idle", se_resp[e].tready, 0);
    end
    chk("drop_cnt", drop_cnt, dropped);
    @(posedge clk);
    #1;
    if (ihs) begin
      h = iq.pop_front();
      if (irem == 0) begin
        irem = int'(h[DataW-1:TypeW]);
        if (idrop && dropped < 65535) dropped++;
      end else begin
        irem--;
      end
    end
    if (ehs) begin
      h = eq[g].pop_front();
      if (egnt < 0) begin
        rr = (g + 1) % N;
        if (h[DataW-1:TypeW] != 0) begin
          egnt = g;
          erem = int'(h[DataW-1:TypeW]);
        end
      end else begin
        erem--;
        if (erem == 0) egnt = -1;
      end
    end
  endtask

  task automatic run(input int mode, input int maxc);
    int n;
    n = 0;
    while (busy() && n < maxc) begin
      step(mode);
      n++;
    end
    chk("drain", busy(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_req.tvalid  = 1'b1;
    s_req.t.data  = $urandom;
    m_resp.tready = 1'b1;
    for (int e = 0; e < N; e++) begin
      se_req[e].tvalid  = 1'b1;
      se_req[e].t.data  = $urandom;
      me_resp[e].tready = 1'b1;
    end
    repeat (2) begin
      #4;
      chk("rst_s_rdy", s_resp.tready, 0);
      chk("rst_m_vld", m_req.tvalid, 0);
      for (int e = 0; e < N; e++) begin
        chk("rst_eng_vld", me_req[e].tvalid, 0);
        chk("rst_se_rdy", se_resp[e].tready, 0);
      end
      @(posedge clk);
      #1;
    end
    chk("rst_drop", drop_cnt, 0);
    reset = 1'b0;
    iq.delete();
    for (int e = 0; e < N; e++) eq[e].delete();
    irem    = 0;
    dropped = 0;
    rr      = 0;
    egnt    = -1;
    erem    = 0;
  endtask

  initial begin
    reset = 1'b1;
    for (int e = 0; e < N; e++) rt_type[e] = TypeW'(e + 1);
    rt_en = 4'b0110;
    @(posedge clk);
    #1;
    do_reset();

    // type 0x02 len 3 -> engine 1; type 0x01 len 0 -> default engine 3
    add_in(8'h02, 3);
    add_in(8'h01, 0);
    add_in(8'h03, 1);
    run(0, 50);

    // all engines return 2-beat packets: order 0,1,2,3 then 0 again
    for (int e = 0; e < N; e++) add_eg(e, e + 1, 1);
    run(0, 50);
    for (int e = 0; e < N; e++) add_eg(e, e + 1, 1);
    run(0, 50);

    // engine 1 stalls mid-packet while the table changes
    add_in(8'h02, 6);
    step(0);
    step(0);
    repeat (5) begin
      rt_en = ~rt_en;
      step(2);
    end
    rt_en = 4'b0110;
    run(0, 50);

    // oversize packet followed by a normal one
    add_in(8'h05, 200);
    add_in(8'h02, 1);
    run(0, 400);

    // random concurrent traffic with a changing table
    for (int r = 0; r < 6; r++) begin
      int n;
      for (int p = 0; p < 4; p++) begin
        add_in($urandom_range(1, 6),
               ($urandom_range(0, 9) == 0) ? $urandom_range(129, 140)
                                           : $urandom_range(0, 5));
      end
      for (int e = 0; e < N; e++) begin
        repeat ($urandom_range(0, 2)) add_eg(e, $urandom_range(1, 6),
                                             $urandom_range(0, 4));
      end
      n = 0;
      while (busy() && n < 3000) begin
        if ($urandom_range(0, 7) == 0) begin
          rt_en = N'($urandom);
          rt_type[$urandom_range(0, N - 1)] = TypeW'($urandom_range(1, 6));
        end
        step(1);
        n++;
      end
      chk("rand_drain", busy(), 0);
    end

    // reset in the middle of packets on both sides
    for (int e = 0; e < N; e++) rt_type[e] = TypeW'(e + 1);
    rt_en = 4'b0110;
    add_in(8'h02, 5);
    add_eg(1, 2, 3);
    add_eg(2, 3, 3);
    step(0);
    step(0);
    do_reset();
    add_in(8'h03, 0);
    add_in(8'h02, 1);
    for (int e = N - 1; e >= 0; e--) add_eg(e, e + 1, 0);
    run(0, 50);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
